// File: rtl/eth_pcs_params_pkg.sv
// eth_pcs_params: shared PCS parameters, TX sequencer state type and the
// gearbox sequence advance helper.
package eth_pcs_params;

  // XGMII transactions per 64-bit block and width of the transaction index
  localparam int unsigned N_TRANS_PER_BLK = 2;
  localparam int unsigned W_TRANS_PER_BLK = (N_TRANS_PER_BLK > 1) ? $clog2(N_TRANS_PER_BLK) : 1;

  // TX gearbox sequence: 0..GB_SEQ_MAX, where GB_SEQ_MAX is the pause slot
  localparam int unsigned W_GB_SEQ   = 6;
  localparam int unsigned GB_SEQ_MAX = 32;

  typedef enum logic [1:0] {
    TX_SEQ_IDLE     = 2'd0,
    TX_SEQ_WAIT_PHY = 2'd1,
    TX_SEQ_RUN      = 2'd2
  } tx_seq_state_e;

  // Gearbox sequence value for the next cycle given the current sub-index
  function automatic logic [W_GB_SEQ-1:0] gb_seq_advance(
    input logic [W_TRANS_PER_BLK-1:0] sub,
    input logic [W_GB_SEQ-1:0]        gb
  );
    if (sub != W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1)) return gb;
    if (gb == W_GB_SEQ'(GB_SEQ_MAX)) return '0;
    return gb + W_GB_SEQ'(1);
  endfunction

endpackage

// File: rtl/eth_pcs_ready_filter.sv
// eth_pcs_ready_filter: consecutive-cycle qualifier for a ready/lock input.
// o_locked is high when LOCK_CYCLES-1 consecutive i_ready cycles have been
// counted, so (o_locked & i_ready) marks the LOCK_CYCLES-th consecutive
// ready cycle. o_locked_next_c is the value o_locked takes next cycle.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_clear              hold the count at 0 (outside the counting state)
//   i_ready              qualified input
//   o_locked             registered lock qualifier
//   o_locked_next_c      look-ahead of o_locked (combinational)
module eth_pcs_ready_filter #(
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_ready,
  output logic o_locked,
  output logic o_locked_next_c
);

  localparam int unsigned W_CNT = $clog2(LOCK_CYCLES + 1);

  logic [W_CNT-1:0] lock_cnt;
  logic [W_CNT-1:0] lock_cnt_d;

  // Count consecutive ready cycles, saturating at LOCK_CYCLES
  always_comb begin
    lock_cnt_d = lock_cnt;
    if (i_clear || !i_ready) begin
      lock_cnt_d = '0;
    end else if (lock_cnt != W_CNT'(LOCK_CYCLES)) begin
      lock_cnt_d = lock_cnt + W_CNT'(1);
    end
    o_locked_next_c = (32'(lock_cnt_d) + 32'd1) >= LOCK_CYCLES;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lock_cnt <= '0;
      o_locked <= (LOCK_CYCLES == 1);
    end else begin
      lock_cnt <= lock_cnt_d;
      o_locked <= o_locked_next_c;
    end
  end

endmodule

// File: rtl/eth_pcs_tx_seq_ctrl.sv
// eth_pcs_tx_seq_ctrl: TX-side PCS sequencer. Brings the TX path up after a
// stable transceiver ready, then drives the encoder/scrambler clock enable,
// transaction index and gearbox sequence, pausing one block in every 33.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_enable              software TX enable (level)
//   i_phy_tx_ready        transceiver TX ready
//   o_clk_en              datapath enable
//   o_trans_cnt           transaction index within the block
//   o_gb_seq              gearbox sequence 0..GB_SEQ_MAX
//   o_hdr_valid           sync header valid
//   o_pld_valid           encoder output holds a real block
//   o_xgmii_ready_next    o_clk_en will be 1 next cycle
//   o_running             state is RUN
//   o_blk_cnt             completed block count (wraps)
module eth_pcs_tx_seq_ctrl
  import eth_pcs_params::*;
#(
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_phy_tx_ready,
  output logic                       o_clk_en,
  output logic [W_TRANS_PER_BLK-1:0] o_trans_cnt,
  output logic [W_GB_SEQ-1:0]        o_gb_seq,
  output logic                       o_hdr_valid,
  output logic                       o_pld_valid,
  output logic                       o_xgmii_ready_next,
  output logic                       o_running,
  output logic [31:0]                o_blk_cnt
);

  localparam logic [W_TRANS_PER_BLK-1:0] SUB_LAST = W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1);
  localparam logic [W_GB_SEQ-1:0]        GB_LAST  = W_GB_SEQ'(GB_SEQ_MAX);

  tx_seq_state_e              state, state_d;
  logic [W_TRANS_PER_BLK-1:0] sub, sub_d;
  logic [W_GB_SEQ-1:0]        gb_d;
  logic [W_TRANS_PER_BLK-1:0] trans_d;
  logic [31:0]                blk_d;
  logic                       clk_en_d, hdr_d, pld_d, ready_next_d, running_d;
  logic                       stay_run, blk_done;
  logic                       clear_c, locked, locked_next_c;

  // Lock counter only runs while waiting for the PHY; cleared elsewhere
  assign clear_c = (state != TX_SEQ_WAIT_PHY);

  eth_pcs_ready_filter #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_ready_filter (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_clear         (clear_c),
    .i_ready         (i_phy_tx_ready),
    .o_locked        (locked),
    .o_locked_next_c (locked_next_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d      = state;
    sub_d        = '0;
    gb_d         = '0;
    trans_d      = '0;
    clk_en_d     = 1'b0;
    hdr_d        = 1'b0;
    pld_d        = 1'b0;
    ready_next_d = 1'b0;
    running_d    = 1'b0;
    blk_done     = o_clk_en && (o_trans_cnt == SUB_LAST);
    blk_d        = o_blk_cnt + 32'(blk_done);

    case (state)
      TX_SEQ_IDLE:     if (i_enable) state_d = TX_SEQ_WAIT_PHY;
      TX_SEQ_WAIT_PHY: if (locked && i_phy_tx_ready) state_d = TX_SEQ_RUN;
      TX_SEQ_RUN:      if (!i_phy_tx_ready) state_d = TX_SEQ_WAIT_PHY;
      default:         state_d = TX_SEQ_IDLE;
    endcase
    if (!i_enable) state_d = TX_SEQ_IDLE;

    // Sequencing counters only advance while staying in RUN; entry and exit
    // both land on zero, abandoning any partial block.
    stay_run = (state == TX_SEQ_RUN) && (state_d == TX_SEQ_RUN);
    if (stay_run) begin
      sub_d = (sub == SUB_LAST) ? '0 : sub + W_TRANS_PER_BLK'(1);
      gb_d  = gb_seq_advance(sub, o_gb_seq);
    end

    running_d = (state_d == TX_SEQ_RUN);
    clk_en_d  = running_d && (gb_d != GB_LAST);
    trans_d   = clk_en_d ? sub_d : '0;
    hdr_d     = clk_en_d && (sub_d == '0);
    pld_d     = stay_run && (o_pld_valid || blk_done);

    // Predict next cycle's clk_en assuming enable and ready stay high
    case (state_d)
      TX_SEQ_WAIT_PHY: ready_next_d = locked_next_c;
      TX_SEQ_RUN:      ready_next_d = (gb_seq_advance(sub_d, gb_d) != GB_LAST);
      default:         ready_next_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state              <= TX_SEQ_IDLE;
      sub                <= '0;
      o_gb_seq           <= '0;
      o_trans_cnt        <= '0;
      o_clk_en           <= 1'b0;
      o_hdr_valid        <= 1'b0;
      o_pld_valid        <= 1'b0;
      o_xgmii_ready_next <= 1'b0;
      o_running          <= 1'b0;
      o_blk_cnt          <= '0;
    end else begin
      state              <= state_d;
      sub                <= sub_d;
      o_gb_seq           <= gb_d;
      o_trans_cnt        <= trans_d;
      o_clk_en           <= clk_en_d;
      o_hdr_valid        <= hdr_d;
      o_pld_valid        <= pld_d;
      o_xgmii_ready_next <= ready_next_d;
      o_running          <= running_d;
      o_blk_cnt          <= blk_d;
    end
  end

endmodule

// File: tb/tb_eth_pcs_tx_seq_ctrl.sv
// Scoreboard bench for eth_pcs_tx_seq_ctrl: stimulus schedules expected
// values per cycle into a queue, the monitor compares them at each negedge
// and also tracks the look-ahead and pause cadence during a long RUN window.
module tb_eth_pcs_tx_seq_ctrl;
  import eth_pcs_params::*;

  logic                       clk = 1'b0;
  logic                       rst, en, rdy;
  logic                       clk_en, hdr, pld, rnext, running;
  logic [W_TRANS_PER_BLK-1:0] trans;
  logic [W_GB_SEQ-1:0]        gb;
  logic [31:0]                blk;

  eth_pcs_tx_seq_ctrl #(.LOCK_CYCLES(16)) dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_enable           (en),
    .i_phy_tx_ready     (rdy),
    .o_clk_en           (clk_en),
    .o_trans_cnt        (trans),
    .o_gb_seq           (gb),
    .o_hdr_valid        (hdr),
    .o_pld_valid        (pld),
    .o_xgmii_ready_next (rnext),
    .o_running          (running),
    .o_blk_cnt          (blk)
  );

  always #5 clk = ~clk;

  localparam int S_RUN = 0, S_CLK = 1, S_GB = 2, S_TR = 3, S_HDR = 4, S_PLD = 5, S_RN = 6, S_BLK = 7;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   inv_on = 1'b0;
  int   run_base = 0;
  logic prev_rn = 1'b0;

  // Schedule an expected value for absolute cycle c (kept sorted by cycle)
  function automatic void ex(int c, int s, logic [31:0] v, string n);
    exp_t e;
    int   i;
    e.cyc = c; e.sig = s; e.val = v; e.name = n;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endfunction

  function automatic logic [31:0] sig_val(int s);
    case (s)
      S_RUN:   return 32'(running);
      S_CLK:   return 32'(clk_en);
      S_GB:    return 32'(gb);
      S_TR:    return 32'(trans);
      S_HDR:   return 32'(hdr);
      S_PLD:   return 32'(pld);
      S_RN:    return 32'(rnext);
      default: return blk;
    endcase
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", n, cyc, act, req);
    end
  endtask

  // Monitor: scheduled expectations plus look-ahead/cadence in the RUN window
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    logic exp_ce;
    if (inv_on) begin
      rel    = cyc - run_base;
      exp_ce = (rel % 66) < 64;
      chk("lookahead", 32'(clk_en), 32'(prev_rn));
      chk("cadence_clk_en", 32'(clk_en), 32'(exp_ce));
      chk("cadence_hdr", 32'(hdr), 32'(exp_ce && (rel % 2 == 0)));
    end
    prev_rn = rnext;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s expectation for cycle %0d not evaluated", e.name, e.cyc);
      end else begin
        chk(e.name, sig_val(e.sig), e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) step();
  endtask

  task automatic ex_all_zero(int c, string n);
    for (int s = 0; s <= S_BLK; s++) ex(c, s, 32'd0, n);
  endtask

  initial begin
    int t0, r, l, a, r2, p, r3, qc;
    rst = 1'b1; en = 1'b0; rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
    ex_all_zero(2, "reset_outputs");
    ex(3, S_RUN, 0, "idle_not_running");

    // Bring-up: enable at t0, ready from t0+5, RUN at t0+21
    t0 = 4;
    r  = t0 + 21;
    ex(t0 + 19, S_RN,  0, "bringup_rnext_early");
    ex(t0 + 20, S_RUN, 0, "bringup_not_yet");
    ex(t0 + 20, S_RN,  1, "bringup_rnext");
    ex(r, S_RUN, 1, "bringup_running");
    ex(r, S_CLK, 1, "bringup_clk_en");
    ex(r, S_GB,  0, "bringup_gb");
    ex(r, S_TR,  0, "bringup_trans");
    ex(r, S_HDR, 1, "bringup_hdr");
    ex(r, S_PLD, 0, "pld_c0");
    ex(r + 1, S_PLD, 0, "pld_c1");
    ex(r + 2, S_PLD, 1, "pld_c2");
    // Pause cadence relative to RUN entry
    ex(r + 63, S_GB,  31, "pre_pause_gb");
    ex(r + 63, S_TR,  1,  "pre_pause_trans");
    ex(r + 63, S_RN,  0,  "pre_pause_rnext");
    ex(r + 64, S_CLK, 0,  "pause_clk_en_64");
    ex(r + 64, S_GB,  32, "pause_gb_64");
    ex(r + 64, S_TR,  0,  "pause_trans");
    ex(r + 64, S_BLK, 32, "pause_blk");
    ex(r + 65, S_CLK, 0,  "pause_clk_en_65");
    ex(r + 65, S_GB,  32, "pause_gb_65");
    ex(r + 65, S_RN,  1,  "pause_end_rnext");
    ex(r + 66, S_GB,  0,  "post_pause_gb");
    ex(r + 66, S_CLK, 1,  "post_pause_clk_en");
    ex(r + 66, S_BLK, 32, "post_pause_blk");
    ex(r + 130, S_GB, 32, "pause2_gb");
    ex(r + 132, S_BLK, 64, "pause2_blk");
    // Ready loss at a trans_cnt=0 cycle, 1000 cycles into RUN
    l = r + 1000;
    ex(l, S_GB,  5,   "pre_loss_gb");
    ex(l, S_TR,  0,   "pre_loss_trans");
    ex(l, S_BLK, 485, "pre_loss_blk");
    ex(l + 1, S_RUN, 0,   "loss_running");
    ex(l + 1, S_CLK, 0,   "loss_clk_en");
    ex(l + 1, S_GB,  0,   "loss_gb");
    ex(l + 1, S_TR,  0,   "loss_trans");
    ex(l + 1, S_HDR, 0,   "loss_hdr");
    ex(l + 1, S_PLD, 0,   "loss_pld");
    ex(l + 1, S_RN,  0,   "loss_rnext");
    ex(l + 1, S_BLK, 485, "loss_blk_kept");
    // Lock filter: 15 ready, 1 drop, then 16 ready
    a  = l + 3;
    r2 = a + 32;
    ex(a + 16, S_RUN, 0, "lock_no_early_run");
    ex(a + 31, S_RUN, 0, "lock_restart_wait");
    ex(a + 31, S_RN,  1, "lock_rnext");
    ex(r2, S_RUN, 1, "relock_running");
    ex(r2, S_BLK, 485, "relock_blk");
    ex(r2, S_PLD, 0, "relock_pld0");
    ex(r2 + 2, S_PLD, 1, "relock_pld2");
    ex(r2 + 2, S_BLK, 486, "relock_blk2");
    // Enable and ready drop together: must go to IDLE, not WAIT_PHY
    p  = r2 + 10;
    r3 = p + 18;
    ex(p, S_GB, 5, "prio_pre_gb");
    ex(p + 1, S_RUN, 0, "prio_running");
    ex(p + 1, S_CLK, 0, "prio_clk_en");
    ex(p + 1, S_GB,  0, "prio_gb");
    ex(p + 1, S_PLD, 0, "prio_pld");
    ex(p + 1, S_BLK, 490, "prio_blk");
    ex(p + 17, S_RUN, 0, "prio_idle_path");
    ex(r3, S_RUN, 1, "prio_rerun");
    // Reset while running
    qc = r3 + 5;
    ex(qc, S_RUN, 1, "prerst_running");
    ex(qc, S_BLK, 492, "prerst_blk");
    ex_all_zero(qc + 1, "rst_in_run");
    ex(qc + 2, S_RUN, 0, "post_rst_running");

    wait_to(t0);
    en = 1'b1;
    wait_to(t0 + 5);
    rdy = 1'b1;
    wait_to(r + 1);
    run_base = r;
    inv_on = 1'b1;
    wait_to(l);
    rdy = 1'b0;
    wait_to(l + 1);
    inv_on = 1'b0;
    wait_to(a);
    rdy = 1'b1;
    wait_to(a + 15);
    rdy = 1'b0;
    wait_to(a + 16);
    rdy = 1'b1;
    wait_to(p);
    en = 1'b0;
    rdy = 1'b0;
    wait_to(p + 1);
    en = 1'b1;
    rdy = 1'b1;
    wait_to(qc);
    rst = 1'b1;
    wait_to(qc + 1);
    rst = 1'b0;
    wait_to(qc + 5);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
